// File: rtl/ccta_pkg.sv
// ccta_pkg: mode encodings shared by the CCTA combine blocks and their benches.
package ccta_pkg;
    localparam logic [1:0] MODE_AB  = 2'b00;
    localparam logic [1:0] MODE_BC  = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;
    localparam logic [1:0] MODE_ACC = 2'b11;
endpackage

// File: rtl/ccta_alu.sv
// ccta_alu: combinational stage-2 datapath (sums, 3-way max, clear-first saturating accumulate).
module ccta_alu
    import ccta_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [1:0]       mode_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic             clr_i,
    output logic [ACC_W-1:0] res_o,
    output logic [ACC_W-1:0] acc_o,
    output logic             sat_o
);
    localparam int AW1 = ACC_W + 1;
    logic [WIDTH-1:0] mx_ab, mx;
    logic [ACC_W:0]   nxt;
    always_comb begin
        mx_ab = (a_i > b_i) ? a_i : b_i;
        mx    = (mx_ab > c_i) ? mx_ab : c_i;
        // one extra bit catches the carry that marks a clamp
        nxt   = (clr_i ? '0 : AW1'(acc_i)) + AW1'(a_i) + AW1'(b_i) + AW1'(c_i);
        sat_o = nxt[ACC_W];
        acc_o = sat_o ? '1 : nxt[ACC_W-1:0];
        res_o = (mode_i == MODE_AB)  ? ACC_W'(a_i) + ACC_W'(b_i)
              : (mode_i == MODE_BC)  ? ACC_W'(b_i) + ACC_W'(c_i)
              : (mode_i == MODE_MAX) ? ACC_W'(mx)
              : acc_o;
    end
endmodule

// File: rtl/ccta_pipe.sv
// ccta_pipe: 2-stage valid/ready CCTA combine unit with saturating accumulator and sticky flag.
module ccta_pipe
    import ccta_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [1:0]       mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             acc_clr_i,
    output logic [ACC_W-1:0] q_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             sat_o
);
    if (ACC_W < WIDTH + 2 || WIDTH < 2) begin : g_chk
        $error("ccta_pipe: need WIDTH >= 2 and ACC_W >= WIDTH+2");
    end

    logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, sat_q, sat_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [ACC_W-1:0] q_q, q_d, acc_q, acc_d, alu_res, alu_acc;
    logic             alu_sat, adv2, take, acc_adv;

    ccta_alu #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_alu (
        .a_i(s1_a_q), .b_i(s1_b_q), .c_i(s1_c_q), .mode_i(s1_mode_q),
        .acc_i(acc_q), .clr_i(acc_clr_i),
        .res_o(alu_res), .acc_o(alu_acc), .sat_o(alu_sat)
    );

    always_comb begin
        adv2        = s1_valid_q && (!out_valid_q || out_ready_i);
        in_ready_o  = !s1_valid_q || adv2;
        take        = in_valid_i && in_ready_o;
        acc_adv     = adv2 && (s1_mode_q == MODE_ACC);
        s1_valid_d  = take || (s1_valid_q && !adv2);
        s1_a_d      = take ? a_i : s1_a_q;
        s1_b_d      = take ? b_i : s1_b_q;
        s1_c_d      = take ? c_i : s1_c_q;
        s1_mode_d   = take ? mode_i : s1_mode_q;
        out_valid_d = adv2 || (out_valid_q && !out_ready_i);
        q_d         = adv2 ? alu_res : q_q;
        // the ALU already folds a same-edge clear into alu_acc/alu_sat
        acc_d       = acc_adv ? alu_acc : (acc_clr_i ? '0 : acc_q);
        sat_d       = (acc_adv && alu_sat) || (sat_q && !acc_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
        end
    end

    assign q_o         = q_q;
    assign out_valid_o = out_valid_q;
    assign sat_o       = sat_q;
endmodule

// File: tb/tb_ccta_pipe.sv
// tb_ccta_pipe: directed and randomized checks of ccta_pipe against a plain-arithmetic model.
module tb_ccta_pipe;
    import ccta_pkg::*;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0;
    logic [1:0] mode = '0;
    logic       in_valid = 1'b0, in_ready, acc_clr = 1'b0;
    logic [5:0] q;
    logic       out_valid, out_ready = 1'b1, sat;
    int         tests = 0, fails = 0, cyc = 0;
    logic [6:0] got_q[$];
    bit         rnd_on = 1'b0;

    ccta_pipe #(.WIDTH(4), .ACC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .c_i(c), .mode_i(mode),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .acc_clr_i(acc_clr),
        .q_o(q), .out_valid_o(out_valid), .out_ready_i(out_ready), .sat_o(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // every consumed output, recorded as {sat, q}
    always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back({sat, q});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input int ia, input int ib, input int ic, input int im);
        bit done = 1'b0;
        a = ia[3:0]; b = ib[3:0]; c = ic[3:0]; mode = im[1:0]; in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
        #1;
        if (got_q.size() < n) begin
            tests++; fails++;
            $display("FAIL wait_timeout: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic pulse_clr();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        tests += 4;
        if (q !== 6'd0) begin fails++; $display("FAIL reset_q: got %0d, want 0", q); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b, want 0", sat); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        int t0;
        got_q.delete();
        a = 4'd3; b = 4'hD; c = 4'd0; mode = MODE_AB; in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL modes_ready: got %b, want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early: out_valid=%b, want 0", out_valid); end
        @(negedge clk);
        tests += 2;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_due: out_valid=%b, want 1", out_valid); end
        if (q !== 6'd16) begin fails++; $display("FAIL mode_ab: got %0d, want 16", q); end
        @(posedge clk); #1;
        t0 = cyc;
        send(0, 2, 1, MODE_BC);
        send(13, 6, 13, MODE_MAX);
        send(3, 13, 0, MODE_AB);
        tests++;
        if (cyc - t0 !== 3) begin fails++; $display("FAIL throughput: %0d cycles for 3 beats, want 3", cyc - t0); end
        wait_n(4);
        if (got_q.size() >= 4) begin
            tests += 3;
            if (got_q[1] !== 7'd3) begin fails++; $display("FAIL mode_bc: got %0d, want 3", got_q[1]); end
            if (got_q[2] !== 7'd13) begin fails++; $display("FAIL mode_max: got %0d, want 13", got_q[2]); end
            if (got_q[3] !== 7'd16) begin fails++; $display("FAIL mode_ab_b2b: got %0d, want 16", got_q[3]); end
        end
    endtask

    task automatic test_accumulate();
        logic [6:0] exp_v[4] = '{7'd21, 7'd35, {1'b1, 6'd63}, {1'b1, 6'd63}};
        got_q.delete();
        pulse_clr();
        send(6, 5, 10, MODE_ACC);
        send(5, 7, 2, MODE_ACC);
        send(15, 2, 14, MODE_ACC);
        send(1, 1, 1, MODE_ACC);
        wait_n(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_v[i]) begin
                fails++;
                $display("FAIL accumulate[%0d]: got sat=%b q=%0d, want sat=%b q=%0d",
                         i, got_q[i][6], got_q[i][5:0], exp_v[i][6], exp_v[i][5:0]);
            end
        end
        pulse_clr();
        @(negedge clk);
        tests++;
        if (sat !== 1'b0) begin fails++; $display("FAIL sat_clear: got %b, want 0", sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear_acc();
        got_q.delete();
        pulse_clr();
        send(6, 5, 10, MODE_ACC);
        send(5, 7, 2, MODE_ACC);
        wait_n(2);
        tests++;
        if (got_q.size() < 2 || got_q[1] !== 7'd35) begin fails++; $display("FAIL acc_to_35: got %0d, want 35", got_q.size() < 2 ? 0 : int'(got_q[1])); end
        a = 4'd1; b = 4'd2; c = 4'd3; mode = MODE_ACC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        @(negedge clk);
        tests += 2;
        if (out_valid !== 1'b1 || q !== 6'd6) begin fails++; $display("FAIL clear_plus_acc: got valid=%b q=%0d, want valid=1 q=6", out_valid, q); end
        if (sat !== 1'b0) begin fails++; $display("FAIL clear_plus_acc_sat: got %b, want 0", sat); end
        @(posedge clk); #1;
        send(0, 0, 1, MODE_ACC);
        wait_n(4);
        tests++;
        if (got_q.size() < 4 || got_q[3] !== 7'd7) begin fails++; $display("FAIL acc_after_clear: got %0d, want 7", got_q.size() < 4 ? 0 : int'(got_q[3])); end
    endtask

    task automatic test_backpressure();
        int va[3], vb[3], vc[3], vm[3];
        logic [6:0] exp_v[3];
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            va[i] = $urandom_range(0, 15); vb[i] = $urandom_range(0, 15);
            vc[i] = $urandom_range(0, 15); vm[i] = $urandom_range(0, 2);
            exp_v[i] = (vm[i] == 0) ? 7'(va[i] + vb[i]) : (vm[i] == 1) ? 7'(vb[i] + vc[i])
                     : 7'((va[i] >= vb[i] && va[i] >= vc[i]) ? va[i] : (vb[i] >= vc[i]) ? vb[i] : vc[i]);
        end
        out_ready = 1'b0;
        send(va[0], vb[0], vc[0], vm[0]);
        send(va[1], vb[1], vc[1], vm[1]);
        a = va[2][3:0]; b = vb[2][3:0]; c = vc[2][3:0]; mode = vm[2][1:0]; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            acc_clr = (k == 1);
            @(negedge clk);
            tests += 2;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b, want 0", k, in_ready); end
            if (out_valid !== 1'b1 || q !== exp_v[0][5:0]) begin fails++; $display("FAIL bp_hold[%0d]: got valid=%b q=%0d, want valid=1 q=%0d", k, out_valid, q, exp_v[0][5:0]); end
            @(posedge clk); #1;
        end
        acc_clr = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b, want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_n(3);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (got_q.size() !== 3) begin fails++; $display("FAIL bp_count: got %0d results, want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i][5:0] !== exp_v[i][5:0]) begin fails++; $display("FAIL bp_order[%0d]: got %0d, want %0d", i, got_q[i][5:0], exp_v[i][5:0]); end
        end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        pulse_clr();
        send(6, 5, 10, MODE_ACC);
        send(5, 7, 2, MODE_ACC);
        wait_n(2);
        out_ready = 1'b0;
        send(1, 2, 3, MODE_AB);
        send(4, 4, 4, MODE_AB);
        #2 rst_n = 1'b0;
        #1;
        tests += 3;
        if (out_valid !== 1'b0 || q !== 6'd0) begin fails++; $display("FAIL async_reset_out: got valid=%b q=%0d, want 0 0", out_valid, q); end
        if (sat !== 1'b0) begin fails++; $display("FAIL async_reset_sat: got %b, want 0", sat); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL async_reset_ready: got %b, want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        send(1, 1, 1, MODE_ACC);
        wait_n(1);
        repeat (3) @(posedge clk);
        #1;
        tests += 2;
        if (got_q.size() !== 1) begin fails++; $display("FAIL reset_drop: got %0d results, want 1", got_q.size()); end
        if (got_q.size() < 1 || got_q[0] !== 7'd3) begin fails++; $display("FAIL acc_after_reset: got %0d, want 3", got_q.size() < 1 ? 0 : int'(got_q[0])); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int macc = 0, s, e, ra, rb, rc, rm;
            bit msat = 1'b0;
            logic [6:0] exp_q[$];
            pulse_clr();
            got_q.delete();
            rnd_on = 1'b1;
            fork
                begin
                    while (rnd_on) begin
                        @(posedge clk); #1;
                        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join_none
            for (int i = 0; i < 20; i++) begin
                ra = $urandom_range(0, 15); rb = $urandom_range(0, 15);
                rc = $urandom_range(0, 15); rm = $urandom_range(0, 3);
                s = ra + rb + rc;
                if (rm == 0) e = ra + rb;
                else if (rm == 1) e = rb + rc;
                else if (rm == 2) e = (ra >= rb && ra >= rc) ? ra : (rb >= rc) ? rb : rc;
                else begin
                    if (macc + s > 63) begin macc = 63; msat = 1'b1; end
                    else macc = macc + s;
                    e = macc;
                end
                exp_q.push_back({msat, e[5:0]});
                send(ra, rb, rc, rm);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            rnd_on = 1'b0;
            out_ready = 1'b1;
            wait_n(20);
            for (int i = 0; i < 20 && i < got_q.size(); i++) begin
                tests++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random[%0d.%0d]: got sat=%b q=%0d, want sat=%b q=%0d",
                             r, i, got_q[i][6], got_q[i][5:0], exp_q[i][6], exp_q[i][5:0]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_accumulate();
        test_clear_acc();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
